hdmi_tmds_encoder: RTL and testbench



---
 rtl/hdmi_tmds_encoder_pkg.sv | 61 ++++++
 rtl/hdmi_tmds_encoder_if.sv | 24 ++
 rtl/hdmi_tmds_encoder_qm_stage.sv | 31 +++
 rtl/hdmi_tmds_encoder.sv | 107 ++++++++++
 tb/tb_hdmi_tmds_encoder.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/hdmi_tmds_encoder_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_tmds_pkg
// Shared constants and helpers for the TMDS channel encoder: control tokens,
// video guard bands, the TERC4 data-island table, the pipeline mode enum and
// a small popcount helper. Symbols are written MSB first; bit 0 goes on the
// wire first.
// -----------------------------------------------------------------------------
package hdmi_tmds_pkg;

  typedef enum logic [1:0] {CTRL, VIDEO, VGB, ISLAND} mode_e;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  localparam logic [9:0] VGB_CH02 = 10'b1011001100;
  localparam logic [9:0] VGB_CH1  = 10'b0100110011;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = CTRL_TOKEN_00;
      2'b01:   t = CTRL_TOKEN_01;
      2'b10:   t = CTRL_TOKEN_10;
      default: t = CTRL_TOKEN_11;
    endcase
    return t;
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] a);
    logic [9:0] t;
    case (a)
      4'd0:    t = 10'b1010011100;
      4'd1:    t = 10'b1001100011;
      4'd2:    t = 10'b1011100100;
      4'd3:    t = 10'b1011100010;
      4'd4:    t = 10'b0101110001;
      4'd5:    t = 10'b0100011110;
      4'd6:    t = 10'b0110001110;
      4'd7:    t = 10'b0100111100;
      4'd8:    t = 10'b1011001100;
      4'd9:    t = 10'b0100111001;
      4'd10:   t = 10'b0110011100;
      4'd11:   t = 10'b1011000110;
      4'd12:   t = 10'b1010001110;
      4'd13:   t = 10'b1001110001;
      4'd14:   t = 10'b0101100011;
      default: t = 10'b1011000011;
    endcase
    return t;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/hdmi_tmds_encoder_if.sv
// -----------------------------------------------------------------------------
// hdmi_tmds_encoder_if
// Per-channel pixel-side bundle of the TMDS encoder.
//   de_i/vgb_i/island_i : period qualifiers (video > guard band > island > ctrl)
//   data_i  : 8-bit pixel component     aux_i  : TERC4 nibble
//   ctrl_i  : {C1,C0} control bits       tmds_o : 10-bit symbol, LSB first
//   disp_o  : running disparity (debug)
// master = pixel source, slave = encoder.
// -----------------------------------------------------------------------------
interface hdmi_tmds_encoder_if;
  logic              de_i;
  logic              vgb_i;
  logic              island_i;
  logic [7:0]        data_i;
  logic [3:0]        aux_i;
  logic [1:0]        ctrl_i;
  logic [9:0]        tmds_o;
  logic signed [4:0] disp_o;

  modport master (output de_i, vgb_i, island_i, data_i, aux_i, ctrl_i,
                  input  tmds_o, disp_o);
  modport slave  (input  de_i, vgb_i, island_i, data_i, aux_i, ctrl_i,
                  output tmds_o, disp_o);
endinterface

// File: rtl/hdmi_tmds_encoder_qm_stage.sv
// -----------------------------------------------------------------------------
// tmds_qm_stage
// Combinational transition-minimisation stage of 8b/10b TMDS video coding.
//   data_i : pixel component
//   qm_o   : q_m[8:0]; q_m[8]=1 marks the XOR chain, 0 the XNOR chain
// -----------------------------------------------------------------------------
module tmds_qm_stage
  import hdmi_tmds_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [8:0] qm_o
);

  logic [3:0] n1;
  logic       use_xnor;
  logic [7:0] chain;

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    n1       = popcount8(data_i);
    // The N1==4 tie is broken on D[0] so the choice is deterministic.
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !data_i[0]);
    chain    = '0;
    chain[0] = data_i[0];
    for (int i = 1; i < 8; i++) begin
      chain[i] = use_xnor ? ~(chain[i-1] ^ data_i[i]) : (chain[i-1] ^ data_i[i]);
    end
    qm_o = {~use_xnor, chain};
  end

endmodule

// File: rtl/hdmi_tmds_encoder.sv
// -----------------------------------------------------------------------------
// hdmi_tmds_encoder
// One HDMI/DVI TMDS channel: video 8b/10b with DC balance, control tokens,
// TERC4 data-island symbols and video guard bands. Fixed 2-cycle latency in
// every mode; mode and side data travel with q_m so switches are cycle-exact.
//   CHANNEL : 0..2, selects the guard-band pattern
//   clk_i   : pixel clock        rst_i : synchronous active-high reset
//   bus     : hdmi_tmds_encoder_if.slave (inputs, tmds_o, disp_o)
// -----------------------------------------------------------------------------
module hdmi_tmds_encoder
  import hdmi_tmds_pkg::*;
#(
  parameter int unsigned CHANNEL = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  hdmi_tmds_encoder_if.slave   bus
);

  // ---------------- stage 1: q_m and mode ----------------
  logic [8:0] qm_d;
  mode_e      mode_d;

  mode_e      mode_q;
  logic [8:0] qm_q;
  logic [1:0] ctrl_q;
  logic [3:0] aux_q;

  tmds_qm_stage u_qm (
    .data_i (bus.data_i),
    .qm_o   (qm_d)
  );

  always_comb begin
    if (bus.de_i)          mode_d = VIDEO;
    else if (bus.vgb_i)    mode_d = VGB;
    else if (bus.island_i) mode_d = ISLAND;
    else                   mode_d = CTRL;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= CTRL;
      qm_q   <= '0;
      ctrl_q <= 2'b00;
      aux_q  <= '0;
    end else begin
      mode_q <= mode_d;
      qm_q   <= qm_d;
      ctrl_q <= bus.ctrl_i;
      aux_q  <= bus.aux_i;
    end
  end

  // ---------------- stage 2: symbol select and DC balance ----------------
  logic [3:0]        n1;
  logic signed [5:0] diff;      // n1 - n0 of q_m[7:0]
  logic signed [5:0] cnt_ext;
  logic signed [5:0] cnt_sum;
  logic signed [4:0] cnt_d, cnt_q;
  logic [9:0]        tmds_d, tmds_q;

  always_comb begin
    n1      = popcount8(qm_q[7:0]);
    diff    = $signed({1'b0, n1, 1'b0}) - 6'sd8;
    cnt_ext = {cnt_q[4], cnt_q};
    // Any non-video symbol restarts the disparity count from zero.
    cnt_sum = '0;
    tmds_d  = ctrl_token(ctrl_q);
    case (mode_q)
      VIDEO: begin
        if ((cnt_q == 5'sd0) || (diff == 6'sd0)) begin
          tmds_d  = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
          cnt_sum = qm_q[8] ? (cnt_ext + diff) : (cnt_ext - diff);
        end else if (((cnt_q > 5'sd0) && (diff > 6'sd0)) ||
                     ((cnt_q < 5'sd0) && (diff < 6'sd0))) begin
          // Invert the payload to pull the running disparity back toward 0.
          tmds_d  = {1'b1, qm_q[8], ~qm_q[7:0]};
          cnt_sum = cnt_ext - diff + (qm_q[8] ? 6'sd2 : 6'sd0);
        end else begin
          tmds_d  = {1'b0, qm_q[8], qm_q[7:0]};
          cnt_sum = cnt_ext + diff - (qm_q[8] ? 6'sd0 : 6'sd2);
        end
      end
      VGB:     tmds_d = (CHANNEL == 1) ? VGB_CH1 : VGB_CH02;
      ISLAND:  tmds_d = terc4(aux_q);
      default: ;
    endcase
    // The coding rules keep |cnt| <= 10, so the 5-bit truncation is lossless.
    cnt_d = cnt_sum[4:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmds_q <= CTRL_TOKEN_00;
      cnt_q  <= '0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.tmds_o = tmds_q;
  assign bus.disp_o = cnt_q;

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// -----------------------------------------------------------------------------
// tb_hdmi_tmds_encoder
// Directed bench for two encoder instances (CHANNEL 0 and 1) driven in
// lockstep. Each cycle applies one input vector; the expected symbol of that
// vector is held and compared two edges later, matching the fixed latency.
// -----------------------------------------------------------------------------
module tb_hdmi_tmds_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hdmi_tmds_encoder_if bus0 ();
  hdmi_tmds_encoder_if bus1 ();

  hdmi_tmds_encoder #(.CHANNEL(0)) u_dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  hdmi_tmds_encoder #(.CHANNEL(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expectation for the vector sampled at the previous edge.
  logic [9:0] prev_t0, prev_t1;
  logic [4:0] prev_d;
  bit         prev_v = 1'b0;

  int model_cnt;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Independent behavioural model of one video symbol; updates cnt in place.
  function automatic logic [9:0] ref_video(input logic [7:0] d, inout int cnt);
    int         n1, m1, m0;
    bit         xn;
    logic [8:0] q;
    logic [9:0] r;
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !xn;
    m1 = $countones(q[7:0]);
    m0 = 8 - m1;
    if (cnt == 0 || m1 == m0) begin
      r = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      cnt = cnt + (q[8] ? (m1 - m0) : (m0 - m1));
    end else if ((cnt > 0 && m1 > m0) || (cnt < 0 && m0 > m1)) begin
      r = {1'b1, q[8], ~q[7:0]};
      cnt = cnt + (q[8] ? 2 : 0) + m0 - m1;
    end else begin
      r = {1'b0, q[8], q[7:0]};
      cnt = cnt + m1 - m0 - (q[8] ? 0 : 2);
    end
    return r;
  endfunction

  task automatic cycle(input bit r, input bit de, input bit vgb, input bit isl,
                       input logic [7:0] d, input logic [3:0] a, input logic [1:0] c,
                       input logic [9:0] et0, input logic [9:0] et1,
                       input logic [4:0] ed, input string tag);
    logic [9:0] cur_t0, cur_t1;
    logic [4:0] cur_d;
    rst = r;
    bus0.de_i = de;  bus0.vgb_i = vgb;  bus0.island_i = isl;
    bus0.data_i = d; bus0.aux_i = a;    bus0.ctrl_i = c;
    bus1.de_i = de;  bus1.vgb_i = vgb;  bus1.island_i = isl;
    bus1.data_i = d; bus1.aux_i = a;    bus1.ctrl_i = c;
    @(posedge clk);
    #1;
    if (r) begin
      cur_t0 = 10'h354; cur_t1 = 10'h354; cur_d = 5'd0;
    end else begin
      cur_t0 = prev_t0; cur_t1 = prev_t1; cur_d = prev_d;
    end
    if (r || prev_v) begin
      check({tag, "/tmds0"}, bus0.tmds_o, cur_t0);
      check({tag, "/tmds1"}, bus1.tmds_o, cur_t1);
      check({tag, "/disp0"}, {5'b0, bus0.disp_o}, {5'b0, cur_d});
    end
    if (r) begin
      // Stage 1 now holds the reset control-00 symbol.
      prev_t0 = 10'h354; prev_t1 = 10'h354; prev_d = 5'd0;
    end else begin
      prev_t0 = et0; prev_t1 = et1; prev_d = ed;
    end
    prev_v = 1'b1;
  endtask

  task automatic ctl(input logic [1:0] c, input logic [9:0] e, input string tag);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 4'hF, c, e, e, 5'd0, tag);
  endtask

  task automatic vid(input logic [7:0] d, input logic [9:0] e, input logic [4:0] ed,
                     input string tag);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, d, 4'h3, 2'b11, e, e, ed, tag);
  endtask

  task automatic isl(input logic [3:0] a, input logic [9:0] e, input string tag);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, a, 2'b10, e, e, 5'd0, tag);
  endtask

  logic [9:0] terc4_exp [16];
  logic [9:0] e;
  logic [7:0] d;

  initial begin
    terc4_exp = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
                  10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};

    // Reset held with busy video input: output must stay at control 00.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 4'h0, 2'b00, 10'h0, 10'h0, 5'd0, "reset");

    // Release, then control sweep 00,01,10,11.
    ctl(2'b00, 10'h354, "rel0");
    ctl(2'b00, 10'h354, "ctl00");
    ctl(2'b01, 10'h0AB, "ctl01");
    ctl(2'b10, 10'h154, "ctl10");
    ctl(2'b11, 10'h2AB, "ctl11");

    // Video 0x00 three times from cnt=0.
    ctl(2'b00, 10'h354, "pre_v0");
    vid(8'h00, 10'h100, 5'h18, "v00_a");
    vid(8'h00, 10'h3FF, 5'h02, "v00_b");
    vid(8'h00, 10'h100, 5'h1A, "v00_c");
    // Control clears cnt, so 0xFF starts from zero.
    ctl(2'b00, 10'h354, "clr");
    vid(8'hFF, 10'h200, 5'h18, "vFF");

    // Priority: de beats vgb and island; vgb beats island.
    ctl(2'b00, 10'h354, "pre_prio");
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 4'h5, 2'b01, 10'h100, 10'h100, 5'h18, "prio_all");
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 4'h5, 2'b01, 10'h2CC, 10'h133, 5'd0, "prio_gb");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 2'b00, 10'h2CC, 10'h133, 5'd0, "gb");

    // TERC4 sweep, then straight into video (island leaves cnt at 0).
    for (int a = 0; a < 16; a++) isl(4'(a), terc4_exp[a], "terc4");
    vid(8'h00, 10'h100, 5'h18, "isl2vid");

    // Long random video against the behavioural model.
    ctl(2'b00, 10'h354, "pre_rand");
    model_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom);
      e = ref_video(d, model_cnt);
      vid(d, e, model_cnt[4:0], "rand");
      check("bound", {9'b0, ($signed(bus0.disp_o) >= -5'sd10) && ($signed(bus0.disp_o) <= 5'sd10)},
            10'd1);
    end

    // Reset mid-video: in-flight symbols are dropped, cnt restarts at 0.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'hAB, 4'h0, 2'b00, 10'h0, 10'h0, 5'd0, "midrst");
    ctl(2'b00, 10'h354, "post_rst");
    vid(8'h00, 10'h100, 5'h18, "post_vid");
    ctl(2'b00, 10'h354, "flush0");
    ctl(2'b00, 10'h354, "flush1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
